// File: rtl/tie_strap_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tie_strap_pkg : state encoding and helpers for tie_strap_ctrl   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package tie_strap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        APPLY  = 2'd2,
        LOCKED = 2'd3
    } state_e;

    // Counter must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic odd_parity(input logic [64:0] v);
        return ^v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tie_strap_shreg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tie_strap_shreg : LSB-first serial shift register, bit counter  |
// | and last-bit flag for tie_strap_ctrl.  Rev 1.0                  |
// +-----------------------------------------------------------------+
module tie_strap_shreg
    import tie_strap_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift_en,
    input  logic             i_clear,
    input  logic             i_data,
    output logic [NBITS-1:0] o_sr,
    output logic             o_done
);

    localparam int                 C_CNT_W = cnt_width(NBITS);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(NBITS - 1);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    logic [NBITS-1:0]   sr_q, sr_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0]   w_shifted;

    generate
        if (NBITS == 1) begin : g_single
            assign w_shifted = i_data;
        end else begin : g_multi
            assign w_shifted = {i_data, sr_q[NBITS-1:1]};
        end
    endgenerate

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (i_clear) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (i_shift_en) begin
            sr_d  = w_shifted;
            cnt_d = cnt_q + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_sr   = sr_q;
    // High when the next accepted bit completes the word.
    assign o_done = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/tie_strap_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tie_strap_ctrl : reloadable/lockable strap tie-off bank.        |
// | Optional macro TIE_STRAP_PARITY_EN adds an even-parity bit.     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tie_strap_ctrl #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic             cfg_data,
    output logic             cfg_ready,
    input  logic             lock_req,
    output logic [WIDTH-1:0] tie_o,
    output logic             busy,
    output logic             locked,
    output logic             apply_pulse
`ifdef TIE_STRAP_PARITY_EN
    ,
    output logic             par_err
`endif
);
    import tie_strap_pkg::*;

`ifdef TIE_STRAP_PARITY_EN
    localparam int C_NBITS = WIDTH + 1;
`else
    localparam int C_NBITS = WIDTH;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   tie_q, tie_d;
    logic               apply_q, apply_d;
    logic               w_xfer;
    logic               w_shift_en;
    logic               w_clear;
    logic               w_done;
    logic               w_par_ok;
    logic [C_NBITS-1:0] w_sr;

`ifdef TIE_STRAP_PARITY_EN
    logic par_q, par_d;
    assign w_par_ok = ~odd_parity(65'(w_sr));
    assign par_err  = par_q;
`else
    assign w_par_ok = 1'b1;
`endif

    tie_strap_shreg #(
        .NBITS (C_NBITS)
    ) u_shreg (
        .clk        (ck),
        .rst        (rst),
        .i_shift_en (w_shift_en),
        .i_clear    (w_clear),
        .i_data     (cfg_data),
        .o_sr       (w_sr),
        .o_done     (w_done)
    );

    assign cfg_ready = (state_q == IDLE) || (state_q == SHIFT);
    assign w_xfer    = cfg_valid && cfg_ready;

    always_comb begin
        state_d    = state_q;
        tie_d      = tie_q;
        apply_d    = 1'b0;
        w_shift_en = 1'b0;
        w_clear    = 1'b0;
`ifdef TIE_STRAP_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE, SHIFT: begin
                // Lock beats a simultaneous transfer; the bit is dropped.
                if (lock_req) begin
                    state_d = LOCKED;
                    w_clear = 1'b1;
                end else if (w_xfer) begin
                    w_shift_en = 1'b1;
                    state_d    = w_done ? APPLY : SHIFT;
                end
            end
            APPLY: begin
                w_clear = 1'b1;
                if (w_par_ok) begin
                    tie_d   = w_sr[WIDTH-1:0];
                    apply_d = 1'b1;
                end else begin
`ifdef TIE_STRAP_PARITY_EN
                    par_d = 1'b1;
`endif
                end
                state_d = lock_req ? LOCKED : IDLE;
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= IDLE;
            tie_q   <= DEFAULT;
            apply_q <= 1'b0;
`ifdef TIE_STRAP_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tie_q   <= tie_d;
            apply_q <= apply_d;
`ifdef TIE_STRAP_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tie_o       = tie_q;
    assign apply_pulse = apply_q;
    assign busy        = (state_q == SHIFT) || (state_q == APPLY);
    assign locked      = (state_q == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_tie_strap_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_tie_strap_ctrl : directed + random bench with a word-level   |
// | reference model of the strap controller.  Rev 1.0               |
// +-----------------------------------------------------------------+
module tb_tie_strap_ctrl;

    localparam int         WIDTH   = 8;
    localparam logic [7:0] DEFAULT = 8'hA5;
`ifdef TIE_STRAP_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = PAR ? WIDTH + 1 : WIDTH;

    logic             ck = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_data = 1'b0;
    logic             lock_req = 1'b0;
    logic             cfg_ready;
    logic [WIDTH-1:0] tie_o;
    logic             busy;
    logic             locked;
    logic             apply_pulse;
    logic             par_err_w;

    int checks = 0;
    int errors = 0;

    tie_strap_ctrl #(
        .WIDTH   (WIDTH),
        .DEFAULT (DEFAULT)
    ) dut (
        .ck          (ck),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .lock_req    (lock_req),
        .tie_o       (tie_o),
        .busy        (busy),
        .locked      (locked),
        .apply_pulse (apply_pulse)
`ifdef TIE_STRAP_PARITY_EN
        ,
        .par_err     (par_err_w)
`endif
    );

`ifndef TIE_STRAP_PARITY_EN
    assign par_err_w = 1'b0;
`endif

    always #5 ck = ~ck;

    // Word-level model: bits collected so far, pending apply, lock flag.
    logic [WIDTH-1:0] m_tie = DEFAULT;
    logic [64:0]      m_word = '0;
    int               m_n = 0;
    bit               m_apply = 1'b0;
    bit               m_locked = 1'b0;
    bit               m_pulse = 1'b0;
    bit               m_perr = 1'b0;
    bit               m_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge ck) begin
        if (m_valid) begin
            chk("tie_o",       64'(tie_o),       64'(m_tie));
            chk("cfg_ready",   64'(cfg_ready),   64'(!m_locked && !m_apply));
            chk("busy",        64'(busy),        64'(m_apply || (m_n > 0)));
            chk("locked",      64'(locked),      64'(m_locked));
            chk("apply_pulse", 64'(apply_pulse), 64'(m_pulse));
            chk("par_err",     64'(par_err_w),   64'(m_perr));
        end
    end

    // Drive one cycle of inputs, advance the model across the edge.
    task automatic step(input logic v, input logic d, input logic l, input logic r);
        logic [WIDTH-1:0] n_tie;
        logic [64:0]      n_word;
        int               n_n;
        bit               n_apply, n_locked, n_pulse, n_perr;
        bit               ok;
        cfg_valid = v;
        cfg_data  = d;
        lock_req  = l;
        rst       = r;
        n_tie = m_tie; n_word = m_word; n_n = m_n; n_apply = m_apply;
        n_locked = m_locked; n_pulse = 1'b0; n_perr = m_perr;
        if (r) begin
            n_tie = DEFAULT; n_word = '0; n_n = 0; n_apply = 1'b0;
            n_locked = 1'b0; n_perr = 1'b0;
        end else if (m_locked) begin
            n_pulse = 1'b0;
        end else if (m_apply) begin
            ok = PAR ? ((^m_word) == 1'b0) : 1'b1;
            if (ok) begin
                n_tie   = m_word[WIDTH-1:0];
                n_pulse = 1'b1;
            end else begin
                n_perr = 1'b1;
            end
            n_apply = 1'b0; n_n = 0; n_word = '0;
            if (l) n_locked = 1'b1;
        end else if (l) begin
            n_locked = 1'b1; n_n = 0; n_word = '0;
        end else if (v) begin
            n_word[m_n] = d;
            n_n = m_n + 1;
            if (n_n == NB) n_apply = 1'b1;
        end
        @(posedge ck);
        m_tie = n_tie; m_word = n_word; m_n = n_n; m_apply = n_apply;
        m_locked = n_locked; m_pulse = n_pulse; m_perr = n_perr;
        if (r) m_valid = 1'b1;
        #1;
    endtask

    task automatic send_word(input logic [8:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) step(1'b1, w[i], 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("lit_reset_tie",   64'(tie_o),     64'hA5);
        chk("lit_reset_ready", 64'(cfg_ready), 64'd1);
        chk("lit_reset_lock",  64'(locked),    64'd0);
        chk("lit_reset_busy",  64'(busy),      64'd0);

        // 8'h3C with continuous valid (plus parity bit 0 when enabled)
        send_word({1'b0, 8'h3C}, NB);
        chk("lit_apply_ready", 64'(cfg_ready), 64'd0);
        chk("lit_apply_busy",  64'(busy),      64'd1);
        step(1, 0, 0, 0);
        chk("lit_pulse",       64'(apply_pulse), 64'd1);
        chk("lit_tie_3c",      64'(tie_o),       64'h3C);
        chk("lit_busy_drop",   64'(busy),        64'd0);
        step(0, 0, 0, 0);
        chk("lit_pulse_once",  64'(apply_pulse), 64'd0);

        // Partial shift then lock
        step(0, 0, 0, 1);
        send_word(9'h0FF, 4);
        step(0, 0, 1, 0);
        chk("lit_locked",      64'(locked),    64'd1);
        chk("lit_lock_tie",    64'(tie_o),     64'hA5);
        chk("lit_lock_ready",  64'(cfg_ready), 64'd0);
        send_word(9'h1FF, 8);
        chk("lit_lock_hold",   64'(tie_o),     64'hA5);

        // Reset mid-shift, then 8'hFF
        step(0, 0, 0, 1);
        send_word(9'h000, 5);
        step(0, 0, 0, 1);
        send_word(PAR ? 9'h0FF : 9'h0FF, NB);
        step(0, 0, 0, 0);
        chk("lit_tie_ff",      64'(tie_o), 64'hFF);

        // Lock on the same cycle as the last bit
        step(0, 0, 0, 1);
        send_word(9'h00F, NB - 1);
        step(1, 1'b0, 1, 0);
        chk("lit_race_lock",   64'(locked),      64'd1);
        chk("lit_race_pulse",  64'(apply_pulse), 64'd0);
        chk("lit_race_tie",    64'(tie_o),       64'hA5);

`ifdef TIE_STRAP_PARITY_EN
        step(0, 0, 0, 1);
        send_word({1'b1, 8'h01}, 9);
        step(0, 0, 0, 0);
        chk("lit_par_ok_tie",  64'(tie_o), 64'h01);
        send_word({1'b1, 8'h03}, 9);
        step(0, 0, 0, 0);
        chk("lit_par_bad_tie", 64'(tie_o),       64'h01);
        chk("lit_par_err",     64'(par_err_w),   64'd1);
        chk("lit_par_nopulse", 64'(apply_pulse), 64'd0);
        send_word({1'b0, 8'h03}, 9);
        step(0, 0, 0, 0);
        chk("lit_par_sticky",  64'(par_err_w), 64'd1);
        step(0, 0, 0, 1);
        chk("lit_par_clear",   64'(par_err_w), 64'd0);
`endif

        // Randomised traffic
        step(0, 0, 0, 1);
        for (int c = 0; c < 4000; c++) begin
            step(($urandom % 4) != 0, $urandom % 2,
                 ($urandom % 250) == 0, ($urandom % 200) == 0);
        end
        step(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
